wb_writeback_stage: RTL

//  Writeback end of the register-update interface consumed by the decode stage: takes the MEM latch

---
 rtl/wb_writeback_stage_pkg.sv | 27 ++
 rtl/wb_writeback_stage_if.sv | 40 ++++
 rtl/wb_seq_checker.sv | 38 +++
 rtl/wb_writeback_stage.sv | 89 ++++++++
 4 files changed

// File: rtl/wb_writeback_stage_pkg.sv
// Shared types and widths for the writeback stage.
// Optional sequence checker is enabled by defining WB_SEQ_CHECK_EN.
package wb_writeback_stage_pkg;

  localparam int unsigned DBITS            = 32;
  localparam int unsigned REGNOBITS        = 5;
  localparam int unsigned CSRNOBITS        = 4;
  localparam int unsigned CNT_BITS         = 32;
  localparam int unsigned FIRST_INST_COUNT = 1;

  typedef enum logic [0:0] {
    WB_RUN    = 1'b0,
    WB_HALTED = 1'b1
  } wb_state_e;

  // Field order of the bundle committed by decode.
  typedef struct packed {
    logic                 wr_reg;
    logic [REGNOBITS-1:0] wregno;
    logic [DBITS-1:0]     regval;
    logic [CSRNOBITS-1:0] wcsrno;
    logic                 wr_csr;
  } from_wb_to_de_t;

  localparam int unsigned FROM_WB_TO_DE_WIDTH = $bits(from_wb_to_de_t);

endpackage

// File: rtl/wb_writeback_stage_if.sv
// MEM-latch inputs, decode-facing write bundle and retire status of the writeback stage.
// Shared by all builds; WB_SEQ_CHECK_EN only changes what drives seq_err.
interface wb_writeback_stage_if;
  import wb_writeback_stage_pkg::*;

  logic                 mem_valid;
  logic [CNT_BITS-1:0]  mem_inst_count;
  logic [DBITS-1:0]     mem_pc;
  logic                 mem_wr_reg;
  logic [REGNOBITS-1:0] mem_wregno;
  logic                 mem_wr_csr;
  logic [CSRNOBITS-1:0] mem_wcsrno;
  logic [DBITS-1:0]     mem_regval;
  logic                 mem_halt;

  logic                 wr_reg_WB;
  logic [REGNOBITS-1:0] wregno_WB;
  logic [DBITS-1:0]     regval_WB;
  logic [CSRNOBITS-1:0] wcsrno_WB;
  logic                 wr_csr_WB;
  logic [CNT_BITS-1:0]  retired_count;
  logic [DBITS-1:0]     last_pc_WB;
  logic                 halted;
  logic                 seq_err;

  modport master (
    output mem_valid, mem_inst_count, mem_pc, mem_wr_reg, mem_wregno,
           mem_wr_csr, mem_wcsrno, mem_regval, mem_halt,
    input  wr_reg_WB, wregno_WB, regval_WB, wcsrno_WB, wr_csr_WB,
           retired_count, last_pc_WB, halted, seq_err
  );

  modport slave (
    input  mem_valid, mem_inst_count, mem_pc, mem_wr_reg, mem_wregno,
           mem_wr_csr, mem_wcsrno, mem_regval, mem_halt,
    output wr_reg_WB, wregno_WB, regval_WB, wcsrno_WB, wr_csr_WB,
           retired_count, last_pc_WB, halted, seq_err
  );

endinterface

// File: rtl/wb_seq_checker.sv
// In-order inst_count checker: tracks the expected tag and flags any gap (sticky).
// Instantiated by the writeback stage only when WB_SEQ_CHECK_EN is defined.
module wb_seq_checker
  import wb_writeback_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                retire_i,
  input  logic [CNT_BITS-1:0] inst_count_i,
  output logic                seq_err_o
);

  logic [CNT_BITS-1:0] expected_q, expected_d;
  logic                seq_err_q, seq_err_d;

  // Resync to the observed tag on every retire so one gap reports once.
  always_comb begin
    expected_d = expected_q;
    seq_err_d  = seq_err_q;
    if (retire_i) begin
      expected_d = inst_count_i + CNT_BITS'(1);
      if (inst_count_i != expected_q) seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      expected_q <= CNT_BITS'(FIRST_INST_COUNT);
      seq_err_q  <= 1'b0;
    end else begin
      expected_q <= expected_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign seq_err_o = seq_err_q;

endmodule

// File: rtl/wb_writeback_stage.sv
// Last pipeline stage: drives the decode register-write bundle and retires instructions.
// Define WB_SEQ_CHECK_EN to include the in-order inst_count checker (seq_err).
module wb_writeback_stage
  import wb_writeback_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  wb_writeback_stage_if.slave  bus
);

  wb_state_e           state_q, state_d;
  logic [CNT_BITS-1:0] retired_q, retired_d;
  logic [DBITS-1:0]    last_pc_q, last_pc_d;
  logic                halted_q, halted_d;
  logic                retire_c;
  from_wb_to_de_t      de_c;

  // Reset overrides a valid instruction in the same cycle.
  assign retire_c = bus.mem_valid & (state_q == WB_RUN) & ~reset;

  // Zero-latency write bundle; every field is zero unless its enable is set.
  always_comb begin
    de_c = '0;
    if (retire_c && !bus.mem_halt) begin
      if (bus.mem_wr_reg && (bus.mem_wregno != '0)) begin
        de_c.wr_reg = 1'b1;
        de_c.wregno = bus.mem_wregno;
        de_c.regval = bus.mem_regval;
      end
      if (bus.mem_wr_csr) begin
        de_c.wr_csr = 1'b1;
        de_c.wcsrno = bus.mem_wcsrno;
        de_c.regval = bus.mem_regval;
      end
    end
  end

  assign bus.wr_reg_WB = de_c.wr_reg;
  assign bus.wregno_WB = de_c.wregno;
  assign bus.regval_WB = de_c.regval;
  assign bus.wcsrno_WB = de_c.wcsrno;
  assign bus.wr_csr_WB = de_c.wr_csr;

  // Retire bookkeeping; the halt sentinel itself retires and then freezes the stage.
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    last_pc_d = last_pc_q;
    if (retire_c) begin
      retired_d = retired_q + CNT_BITS'(1);
      last_pc_d = bus.mem_pc;
      if (bus.mem_halt) state_d = WB_HALTED;
    end
    halted_d = (state_d == WB_HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WB_RUN;
      retired_q <= '0;
      last_pc_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      last_pc_q <= last_pc_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.retired_count = retired_q;
  assign bus.last_pc_WB    = last_pc_q;
  assign bus.halted        = halted_q;

`ifdef WB_SEQ_CHECK_EN
  wb_seq_checker u_seq_checker (
    .clk          (clk),
    .reset        (reset),
    .retire_i     (retire_c),
    .inst_count_i (bus.mem_inst_count),
    .seq_err_o    (bus.seq_err)
  );
`else
  logic unused_inst_count;
  assign unused_inst_count = ^bus.mem_inst_count;
  assign bus.seq_err       = 1'b0;
`endif

endmodule
